// File: rtl/ml_accel_pkg.sv
// Shared accelerator constants and lane typedefs used by the serial/parallel
// mux and demux blocks.
package ml_accel_pkg;

    localparam int unsigned DEMUX_WIDTH = 16;
    localparam int unsigned DEMUX_SEL_W = 4;

    typedef logic [DEMUX_SEL_W-1:0] lane_sel_t;
    typedef logic [DEMUX_SEL_W:0]   lane_cnt_t;

endpackage : ml_accel_pkg

// File: rtl/decoder_4to16.sv
// One-hot lane enable: asserts bit i_sel of o_onehot when i_en is high.
module decoder_4to16
    import ml_accel_pkg::*;
(
    input  lane_sel_t                    i_sel,
    input  logic                         i_en,
    output logic [DEMUX_WIDTH-1:0]       o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule : decoder_4to16

// File: rtl/demux_x16_deserializer.sv
// 1-to-16 serial-to-parallel demux: a lane counter steers each accepted bit
// into an accumulator; full or flushed words go out through a one-entry slot.
module demux_x16_deserializer
    import ml_accel_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned SEL_W = DEMUX_SEL_W
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_word,
    output logic [SEL_W:0]     out_count,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned     CNT_W    = SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_out_word;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [WIDTH-1:0] w_out_word_nxt;
    logic [CNT_W-1:0] w_out_count_nxt;
    logic             w_out_valid_nxt;

    logic             w_slot_free;
    logic             w_at_last;
    logic             w_flush_pending;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;
    logic [WIDTH-1:0] w_lane_en;
    logic [WIDTH-1:0] w_acc_wr;
    logic [CNT_W-1:0] w_emit_count;

    // Handshake / stall decode from registered state and out_ready
    always_comb begin
        w_slot_free     = !r_out_valid || out_ready;
        w_at_last       = (r_sel == LAST_SEL);
        w_flush_pending = flush && (r_sel != '0);
        w_in_ready      = !((w_at_last || w_flush_pending) && !w_slot_free);
        w_accept        = in_valid && w_in_ready;
        // A flush only fires when there is something to emit and room for it
        w_emit          = (w_accept && w_at_last)
                        || (flush && w_slot_free && (w_flush_pending || w_accept));
        w_emit_count    = CNT_W'(r_sel) + CNT_W'(w_accept);
    end

    decoder_4to16 u_lane_dec (
        .i_sel    (r_sel),
        .i_en     (w_accept),
        .o_onehot (w_lane_en)
    );

    assign w_acc_wr = (r_acc & ~w_lane_en) | (w_lane_en & {WIDTH{in_bit}});

    // Next-state for accumulator, lane counter and output slot
    always_comb begin
        w_acc_nxt       = r_acc;
        w_sel_nxt       = r_sel;
        w_out_word_nxt  = r_out_word;
        w_out_count_nxt = r_out_count;
        w_out_valid_nxt = r_out_valid;

        if (w_emit) begin
            w_out_word_nxt  = w_acc_wr;
            w_out_count_nxt = w_emit_count;
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_sel_nxt       = '0;
        end else begin
            if (w_accept) begin
                w_acc_nxt = w_acc_wr;
                w_sel_nxt = r_sel + SEL_W'(1);
            end
            if (r_out_valid && out_ready) begin
                w_out_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sel       <= '0;
            r_out_word  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_sel       <= w_sel_nxt;
            r_out_word  <= w_out_word_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign sel       = r_sel;
    assign out_word  = r_out_word;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;

endmodule : demux_x16_deserializer

// File: tb/tb_demux_x16_deserializer.sv
// Scoreboard bench for demux_x16_deserializer: per-scenario tasks drive bits,
// a bit-level model pushes expected words, a monitor pops them on handshake.
module tb_demux_x16_deserializer;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  sel;
    logic [15:0] out_word;
    logic [4:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int          n_cmp;
    int          n_fail;
    exp_t        q[$];
    logic [15:0] m_acc;
    int          m_n;

    demux_x16_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .sel       (sel),
        .out_word  (out_word),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: every handshake must match the oldest expected word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_unexpected: got word=%h count=%0d, expected no word", out_word, out_count);
            end else begin
                e = q.pop_front();
                if (out_word !== e.w || out_count !== e.c) begin
                    n_fail++;
                    $display("FAIL monitor_word: got word=%h count=%0d, expected word=%h count=%0d",
                             out_word, out_count, e.w, e.c);
                end
            end
        end
    end

    function automatic void model_accept(input logic b, input logic f);
        m_acc[m_n] = b;
        m_n++;
        if (m_n == 16 || f) begin
            q.push_back('{w: m_acc, c: 5'(m_n)});
            m_acc = '0;
            m_n   = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit (optionally with flush) until it is accepted
    task automatic send_bit(input logic b, input logic f);
        in_bit   = b;
        in_valid = 1'b1;
        flush    = f;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                flush    = 1'b0;
                model_accept(b, f);
                return;
            end
            tick();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_bit_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[i], 1'b0);
        end
    endtask

    // Flush without a bit; completes on the first edge with a free slot
    task automatic do_flush();
        flush = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!out_valid || out_ready) begin
                tick();
                flush = 1'b0;
                q.push_back('{w: m_acc, c: 5'(m_n)});
                m_acc = '0;
                m_n   = 0;
                return;
            end
            tick();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL flush_timeout: out_valid=%b out_ready=%b, expected free slot", out_valid, out_ready);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_acc     = '0;
        m_n       = 0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || sel !== 4'd0 || out_word !== 16'h0 || out_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: got valid=%b sel=%0d word=%h count=%0d, expected 0/0/0000/0",
                     out_valid, sel, out_word, out_count);
        end
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        // Mid-stream reset at lane 7
        out_ready = 1'b1;
        send_word(16'h00FF, 7);
        n_cmp++;
        if (sel !== 4'd7) begin
            n_fail++;
            $display("FAIL reset_pre_sel: got %0d, expected 7", sel);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sel !== 4'd0 || out_word !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_midstream: got valid=%b sel=%0d word=%h, expected 0/0/0000",
                     out_valid, sel, out_word);
        end
        m_acc = '0;
        m_n   = 0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [15:0] wb;
        wb = 16'($urandom);
        out_ready = 1'b1;
        send_word(16'h8001, 16);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 16'h8001 || out_count !== 5'd16 || sel !== 4'd0) begin
            n_fail++;
            $display("FAIL stream_complete: got valid=%b word=%h count=%0d sel=%0d, expected 1/8001/16/0",
                     out_valid, out_word, out_count, sel);
        end
        send_bit(wb[0], 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || sel !== 4'd1) begin
            n_fail++;
            $display("FAIL stream_one_cycle: got valid=%b sel=%0d, expected 0/1", out_valid, sel);
        end
        for (int i = 1; i < 16; i++) begin
            send_bit(wb[i], 1'b0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1;
        logic [15:0] w2;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        out_ready = 1'b0;
        send_word(w1, 16);
        send_word(w2, 15);
        in_bit   = w2[15];
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || sel !== 4'd15 || out_word !== w1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: got ready=%b sel=%0d word=%h valid=%b, expected 0/15/%h/1",
                         in_ready, sel, out_word, out_valid, w1);
            end
            tick();
        end
        out_ready = 1'b1;
        send_bit(w2[15], 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== w2 || out_count !== 5'd16) begin
            n_fail++;
            $display("FAIL b2b_reload: got valid=%b word=%h count=%0d, expected 1/%h/16",
                     out_valid, out_word, out_count, w2);
        end
        tick();
    endtask

    task automatic test_flush_partial();
        out_ready = 1'b1;
        send_word(16'h001B, 5);
        do_flush();
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 16'h001B || out_count !== 5'd5 || sel !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_partial: got valid=%b word=%h count=%0d sel=%0d, expected 1/001b/5/0",
                     out_valid, out_word, out_count, sel);
        end
        tick();
        tick();
    endtask

    task automatic test_flush_zero();
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || sel !== 4'd0) begin
                n_fail++;
                $display("FAIL flush_empty: got valid=%b sel=%0d, expected 0/0", out_valid, sel);
            end
            tick();
        end
        flush = 1'b0;
        send_bit(1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== 16'h0001 || out_count !== 5'd1 || sel !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_one_bit: got valid=%b word=%h count=%0d sel=%0d, expected 1/0001/1/0",
                     out_valid, out_word, out_count, sel);
        end
        tick();
        tick();
    endtask

    task automatic test_flush_last();
        logic [15:0] w;
        w = 16'($urandom);
        out_ready = 1'b1;
        send_word(w, 15);
        send_bit(w[15], 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_word !== w || out_count !== 5'd16) begin
            n_fail++;
            $display("FAIL flush_lane15: got valid=%b word=%h count=%0d, expected 1/%h/16",
                     out_valid, out_word, out_count, w);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush_partial();
        test_flush_zero();
        test_flush_last();
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words still expected, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_demux_x16_deserializer
